// File: rtl/mem_bank_port_arbiter_pkg.sv
// mem_ctrl_pkg: shared FSM state and read-tag types for the bank port arbiter
package mem_ctrl_pkg;
  // Tag id is sized for the largest supported requester count (8)
  localparam int ID_W = 3;
  typedef enum logic {IDLE, OWNED} arb_state_t;
  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
  } rd_tag_t;
endpackage

// File: rtl/mem_bank_port_arbiter_if.sv
// mem_bank_port_arbiter_if: requester and memory-bank signals of one arbitrated port
interface mem_bank_port_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int A_W   = 12,
  parameter int R_W   = 12
);
  logic [N_REQ-1:0]     i_req, i_we, i_lock;
  logic [N_REQ*A_W-1:0] i_addr;
  logic [N_REQ*R_W-1:0] i_din;
  logic [N_REQ-1:0]     o_gnt;
  logic                 o_mem_en, o_mem_we;
  logic [A_W-1:0]       o_mem_addr;
  logic [R_W-1:0]       o_mem_din, i_mem_dout;
  logic [N_REQ-1:0]     o_rvalid;
  logic [R_W-1:0]       o_rdata;
  logic                 o_busy;
  modport slave (
    input  i_req, i_we, i_lock, i_addr, i_din, i_mem_dout,
    output o_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din, o_rvalid, o_rdata, o_busy
  );
  modport master (
    output i_req, i_we, i_lock, i_addr, i_din, i_mem_dout,
    input  o_gnt, o_mem_en, o_mem_we, o_mem_addr, o_mem_din, o_rvalid, o_rdata, o_busy
  );
endinterface

// File: rtl/mem_bank_port_arbiter_tag_pipe.sv
// mem_rd_tag_pipe: RL-deep shift register of read tags with async clear
module mem_rd_tag_pipe
  import mem_ctrl_pkg::*;
#(
  parameter int RL = 2
) (
  input  logic    i_clk,
  input  logic    i_rst,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o,
  output logic    busy_o
);
  rd_tag_t [RL-1:0] pipe_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) pipe_q <= '0;
    else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < RL; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end
  assign tag_o = pipe_q[RL-1];
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < RL; i++) busy_o = busy_o | pipe_q[i].v;
  end
endmodule

// File: rtl/mem_bank_port_arbiter.sv
// mem_bank_port_arbiter: round-robin arbiter with locked bursts and tagged read return
module mem_bank_port_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int A_W       = 12,
  parameter int R_W       = 12,
  parameter int RL        = 2,
  parameter int MAX_BURST = 4
) (
  input logic i_clk,
  input logic i_rst,
  mem_bank_port_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  arb_state_t     state_q, state_d;
  logic [IW-1:0]  ptr_q, ptr_d, own_q, own_d, gid_q, gid, rr_id, idx;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0] mask;
  logic           own_ok, rr_hit, any, en_q, we_q;
  logic [A_W-1:0] addr_q;
  logic [R_W-1:0] din_q;
  rd_tag_t        tag_out;
  always_comb begin
    own_ok = state_q == OWNED && bus.i_req[own_q] && bus.i_lock[own_q];
    mask = bus.i_req & ~((state_q == OWNED) ? N_REQ'(1) << own_q : '0);
    rr_hit = 1'b0;
    rr_id = '0;
    idx = '0;
    // Walk backwards so the nearest requester after the pointer is the last to win
    for (int i = N_REQ; i >= 1; i--) begin
      idx = IW'((int'(ptr_q) + i) % N_REQ);
      if (mask[idx]) begin
        rr_hit = 1'b1;
        rr_id = idx;
      end
    end
    any = own_ok | rr_hit;
    gid = own_ok ? own_q : rr_id;
    ptr_d = ptr_q;
    own_d = own_q;
    state_d = state_q;
    cnt_d = cnt_q;
    if (own_ok) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(MAX_BURST)) begin
        state_d = IDLE;
        ptr_d = own_q;
        cnt_d = '0;
      end
    end else begin
      state_d = IDLE;
      cnt_d = '0;
      if (rr_hit) begin
        ptr_d = rr_id;
        if (bus.i_lock[rr_id] && MAX_BURST > 1) begin
          state_d = OWNED;
          own_d = rr_id;
          cnt_d = CW'(1);
        end
      end
    end
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(N_REQ - 1);
      own_q <= '0;
      cnt_q <= '0;
      en_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      din_q <= '0;
      gid_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      cnt_q <= cnt_d;
      en_q <= any;
      we_q <= any & bus.i_we[gid];
      addr_q <= bus.i_addr[gid*A_W +: A_W];
      din_q <= bus.i_din[gid*R_W +: R_W];
      gid_q <= gid;
    end
  end
  mem_rd_tag_pipe #(.RL(RL)) u_pipe (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .tag_i ('{v: en_q & ~we_q, id: ID_W'(gid_q)}),
    .tag_o (tag_out),
    .busy_o(bus.o_busy)
  );
  assign bus.o_gnt      = any ? N_REQ'(1) << gid : '0;
  assign bus.o_mem_en   = en_q;
  assign bus.o_mem_we   = we_q;
  assign bus.o_mem_addr = addr_q;
  assign bus.o_mem_din  = din_q;
  assign bus.o_rvalid   = tag_out.v ? N_REQ'(1) << tag_out.id : '0;
  assign bus.o_rdata    = tag_out.v ? bus.i_mem_dout : '0;
endmodule

// File: tb/tb_mem_bank_port_arbiter.sv
// tb_mem_bank_port_arbiter: table-driven check of arbitration, bursts, read return and reset
module tb_mem_bank_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [11:0] mem [4096];
  logic [11:0] d0, d1;
  typedef struct {
    logic [3:0]  req, we, lock;
    logic [11:0] addr, din;
    logic [3:0]  gnt;
    logic        en;
    logic [3:0]  rv;
    logic [11:0] rd;
    logic        busy;
  } vec_t;
  vec_t vq[$];
  mem_bank_port_arbiter_if #(.N_REQ(4), .A_W(12), .R_W(12)) bus ();
  mem_bank_port_arbiter #(.N_REQ(4), .A_W(12), .R_W(12), .RL(2), .MAX_BURST(4)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  // Bank model: RL=2, address sampled at the command edge, read-before-write
  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = ~12'(a);
    d0 = '0;
    d1 = '0;
    forever begin
      @(posedge clk);
      d1 = d0;
      if (bus.o_mem_en) begin
        d0 = mem[bus.o_mem_addr];
        if (bus.o_mem_we) mem[bus.o_mem_addr] = bus.o_mem_din;
      end
    end
  end
  assign bus.i_mem_dout = d1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic [3:0] req, we, lock, input logic [11:0] addr, din);
    bus.i_req = req;
    bus.i_we = we;
    bus.i_lock = lock;
    bus.i_addr = {4{addr}};
    bus.i_din = {4{din}};
  endtask
  task automatic add(input logic [3:0] req, we, lock, input logic [11:0] addr, din,
                     input logic [3:0] gnt, input logic en, input logic [3:0] rv,
                     input logic [11:0] rd, input logic busy);
    vq.push_back('{req, we, lock, addr, din, gnt, en, rv, rd, busy});
  endtask
  initial begin
    // all four requesting reads: rotation 0,1,2,3,0 and in-order return
    add(4'hF, 4'h0, 4'h0, 12'h010, 12'h000, 4'h1, 1'b0, 4'h0, 12'h000, 1'b0);
    add(4'hF, 4'h0, 4'h0, 12'h011, 12'h000, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'hF, 4'h0, 4'h0, 12'h012, 12'h000, 4'h4, 1'b1, 4'h0, 12'h000, 1'b1);
    add(4'hF, 4'h0, 4'h0, 12'h013, 12'h000, 4'h8, 1'b1, 4'h1, 12'hFEF, 1'b1);
    add(4'hF, 4'h0, 4'h0, 12'h014, 12'h000, 4'h1, 1'b1, 4'h2, 12'hFEE, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b1, 4'h4, 12'hFED, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h8, 12'hFEC, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h1, 12'hFEB, 1'b1);
    // write by 0 then read back by 2
    add(4'h1, 4'h1, 4'h0, 12'h005, 12'h0AB, 4'h1, 1'b0, 4'h0, 12'h000, 1'b0);
    add(4'h4, 4'h0, 4'h0, 12'h005, 12'h0AB, 4'h4, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h0, 12'h000, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h4, 12'h0AB, 1'b1);
    // locked burst of 4 by requester 1, then 3; second burst broken by lock drop
    add(4'h2, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b0, 4'h0, 12'h000, 1'b0);
    add(4'hA, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'hA, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'hA, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'hA, 4'hF, 4'h2, 12'h100, 12'h123, 4'h8, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h2, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h3, 4'hF, 4'h2, 12'h100, 12'h123, 4'h2, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h3, 4'hF, 4'h0, 12'h100, 12'h123, 4'h1, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h0, 4'hF, 4'h0, 12'h100, 12'h123, 4'h0, 1'b1, 4'h0, 12'h000, 1'b0);
    // back-to-back reads across DPRAM0 and DPRAM3
    add(4'h1, 4'h0, 4'h0, 12'h3FF, 12'h000, 4'h1, 1'b0, 4'h0, 12'h000, 1'b0);
    add(4'h1, 4'h0, 4'h0, 12'hC00, 12'h000, 4'h1, 1'b1, 4'h0, 12'h000, 1'b0);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b1, 4'h0, 12'h000, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h1, 12'hC00, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h1, 12'h3FF, 1'b1);
    add(4'h0, 4'h0, 4'h0, 12'h000, 12'h000, 4'h0, 1'b0, 4'h0, 12'h000, 1'b0);
    drive(4'h0, 4'h0, 4'h0, 12'h000, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst gnt", 32'(bus.o_gnt), 0);
    chk("rst en", 32'(bus.o_mem_en), 0);
    chk("rst we", 32'(bus.o_mem_we), 0);
    chk("rst addr", 32'(bus.o_mem_addr), 0);
    chk("rst rvalid", 32'(bus.o_rvalid), 0);
    chk("rst rdata", 32'(bus.o_rdata), 0);
    chk("rst busy", 32'(bus.o_busy), 0);
    rst = 1'b0;
    foreach (vq[i]) begin
      @(posedge clk);
      #1;
      drive(vq[i].req, vq[i].we, vq[i].lock, vq[i].addr, vq[i].din);
      @(negedge clk);
      chk($sformatf("row%0d gnt", i), 32'(bus.o_gnt), 32'(vq[i].gnt));
      chk($sformatf("row%0d en", i), 32'(bus.o_mem_en), 32'(vq[i].en));
      chk($sformatf("row%0d rvalid", i), 32'(bus.o_rvalid), 32'(vq[i].rv));
      chk($sformatf("row%0d rdata", i), 32'(bus.o_rdata), 32'(vq[i].rd));
      chk($sformatf("row%0d busy", i), 32'(bus.o_busy), 32'(vq[i].busy));
    end
    // reset with two reads in flight
    @(posedge clk);
    #1;
    drive(4'h1, 4'h0, 4'h0, 12'h030, 12'h000);
    @(posedge clk);
    #1;
    drive(4'h1, 4'h0, 4'h0, 12'h031, 12'h000);
    @(posedge clk);
    #1;
    drive(4'h0, 4'h0, 4'h0, 12'h000, 12'h000);
    @(negedge clk);
    chk("inflight busy", 32'(bus.o_busy), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst busy", 32'(bus.o_busy), 0);
    chk("midrst rvalid", 32'(bus.o_rvalid), 0);
    chk("midrst en", 32'(bus.o_mem_en), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("postrst%0d rvalid", i), 32'(bus.o_rvalid), 0);
      chk($sformatf("postrst%0d busy", i), 32'(bus.o_busy), 0);
    end
    @(posedge clk);
    #1;
    drive(4'h1, 4'h0, 4'h0, 12'h040, 12'h000);
    @(negedge clk);
    chk("newrd gnt", 32'(bus.o_gnt), 1);
    @(posedge clk);
    #1;
    drive(4'h0, 4'h0, 4'h0, 12'h000, 12'h000);
    @(negedge clk);
    chk("newrd t1 rvalid", 32'(bus.o_rvalid), 0);
    @(negedge clk);
    chk("newrd t2 rvalid", 32'(bus.o_rvalid), 0);
    @(negedge clk);
    chk("newrd t3 rvalid", 32'(bus.o_rvalid), 1);
    chk("newrd t3 rdata", 32'(bus.o_rdata), 32'h0FBF);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
